// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: skid FSM states,
// default widths and the control-strobe bit positions of the EX/M and M/WB payloads.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam int PIPE_DATA_W = 32 + 32 + 32 + 32 + 5 + 3 + 8;
    localparam int PIPE_CTRL_W = 8;
    localparam int PIPE_CNT_W  = 16;

    // Commit strobes sit in the low byte so the stage can blank them in bubbles.
    localparam int EXM_CTRL_REG_WRITE  = 0;
    localparam int EXM_CTRL_MEM_WRITE  = 1;
    localparam int EXM_CTRL_MEM_READ   = 2;
    localparam int EXM_CTRL_MEM_TO_REG = 3;
    localparam int EXM_CTRL_BRANCH     = 4;
    localparam int EXM_CTRL_JUMP       = 5;
    localparam int EXM_CTRL_CSR_WRITE  = 6;
    localparam int EXM_CTRL_FENCE      = 7;

    localparam int MWB_CTRL_REG_WRITE  = 0;
    localparam int MWB_CTRL_MEM_TO_REG = 1;
    localparam int MWB_CTRL_CSR_WRITE  = 2;

endpackage

// File: rtl/sat_counter.sv
// Width-parametrised saturating up-counter with synchronous clear; clear wins
// over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = W'(1);

    // Count up on inc, stick at all-ones, clear on reset or clr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush, bubble strobe
// blanking and stall counting. Define PIPE_SKID_EN for the registered-ready skid variant.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int CNT_W  = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    input  logic              clr_cnt_i
);

    localparam logic [DATA_W-1:0] ONE_W     = DATA_W'(1);
    // Shift-then-subtract also yields all ones when CTRL_W == DATA_W.
    localparam logic [DATA_W-1:0] CTRL_MASK = (ONE_W << CTRL_W) - ONE_W;

    function automatic logic [DATA_W-1:0] kill_ctrl(input logic [DATA_W-1:0] d);
        return d & ~CTRL_MASK;
    endfunction

    logic              valid_r;
    logic [DATA_W-1:0] main_r;
    logic              xfer_in_s;
    logic              xfer_out_s;
    logic              stall_s;

    assign xfer_out_s  = valid_r && out_ready_i;
    assign stall_s     = valid_r && !out_ready_i;
    assign out_valid_o = valid_r;
    assign out_data_o  = main_r;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt_i),
        .inc   (stall_s),
        .cnt   (stall_cnt_o)
    );

`ifdef PIPE_SKID_EN

    state_e            state_r;
    logic [DATA_W-1:0] skid_r;
    logic              ready_r;

    assign in_ready_o = ready_r;
    assign xfer_in_s  = in_valid_i && ready_r && !flush_i;

    // Skid FSM: main register feeds the output, skid catches the entry that
    // arrives while downstream stalls; ready is registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            main_r  <= '0;
            skid_r  <= '0;
        end else if (flush_i) begin
            state_r <= ST_EMPTY;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
            main_r  <= kill_ctrl(main_r);
            skid_r  <= skid_r;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (xfer_in_s) begin
                        state_r <= ST_BUSY;
                        valid_r <= 1'b1;
                        main_r  <= in_data_i;
                    end else begin
                        state_r <= ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    if (xfer_in_s && xfer_out_s) begin
                        main_r  <= in_data_i;
                    end else if (xfer_in_s) begin
                        state_r <= ST_FULL;
                        ready_r <= 1'b0;
                        skid_r  <= in_data_i;
                    end else if (xfer_out_s) begin
                        state_r <= ST_EMPTY;
                        valid_r <= 1'b0;
                        main_r  <= kill_ctrl(main_r);
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_FULL: begin
                    if (xfer_out_s) begin
                        state_r <= ST_BUSY;
                        ready_r <= 1'b1;
                        main_r  <= skid_r;
                    end else begin
                        state_r <= ST_FULL;
                    end
                end
                default: begin
                    state_r <= ST_EMPTY;
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                    main_r  <= kill_ctrl(main_r);
                end
            endcase
        end
    end

`else

    assign in_ready_o = !valid_r || out_ready_i;
    assign xfer_in_s  = in_valid_i && in_ready_o && !flush_i;

    // Single register: load on transfer in, blank strobes when it empties.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            main_r  <= '0;
        end else if (flush_i) begin
            valid_r <= 1'b0;
            main_r  <= kill_ctrl(main_r);
        end else if (xfer_in_s) begin
            valid_r <= 1'b1;
            main_r  <= in_data_i;
        end else if (xfer_out_s) begin
            valid_r <= 1'b0;
            main_r  <= kill_ctrl(main_r);
        end else begin
            valid_r <= valid_r;
            main_r  <= main_r;
        end
    end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: queue scoreboard plus scenario tasks;
// a second instance with a 4-bit counter covers saturation.
module tb_pipe_stage_reg;

    localparam int DW = 144;
    localparam int CW = 8;
`ifdef PIPE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic          clk;
    logic          rst_n;
    logic          flush_i;
    logic          in_valid_i;
    logic          out_ready_i;
    logic          clr_cnt_i;
    logic [DW-1:0] in_data_i;
    logic          in_ready_o;
    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic [15:0]   stall_cnt_o;
    logic          in_ready_c4;
    logic          out_valid_c4;
    logic [DW-1:0] out_data_c4;
    logic [3:0]    stall_cnt_c4;

    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] stall_d0;
    int            cnt_exp;
    int            cnt4_exp;
    int            n_tests;
    int            n_fail;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .in_data_i(in_data_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_data_o(out_data_o), .stall_cnt_o(stall_cnt_o),
        .clr_cnt_i(clr_cnt_i)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4)) dut_c4 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_c4), .in_data_i(in_data_i), .out_valid_o(out_valid_c4),
        .out_ready_i(out_ready_i), .out_data_o(out_data_c4), .stall_cnt_o(stall_cnt_c4),
        .clr_cnt_i(clr_cnt_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
    endfunction

    function automatic logic exp_ready();
`ifdef PIPE_SKID_EN
        return sb_q.size() < 2;
`else
        return (sb_q.size() == 0) || out_ready_i;
`endif
    endfunction

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic ordy,
                         input logic fl, input logic clr);
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = ordy;
        flush_i     = fl;
        clr_cnt_i   = clr;
        #1;
    endtask

    // Scoreboard: pop/compare on transfer out, push on transfer in, advance counter model.
    task automatic clock_edge();
        logic m_valid;
        logic xin;
        logic xout;
        logic stall;
        m_valid = (sb_q.size() != 0);
        xin     = in_valid_i && exp_ready() && !flush_i;
        xout    = m_valid && out_ready_i;
        stall   = m_valid && !out_ready_i;
        if (rst_n && xout) begin
            n_tests++;
            if (out_data_o !== sb_q[0] || out_data_c4 !== sb_q[0]) begin
                n_fail++;
                $display("FAIL sb_order: got %h / %h, expected %h", out_data_o, out_data_c4, sb_q[0]);
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            sb_q.delete();
            cnt_exp  = 0;
            cnt4_exp = 0;
        end else begin
            if (clr_cnt_i) begin
                cnt_exp  = 0;
                cnt4_exp = 0;
            end else if (stall) begin
                if (cnt_exp < 65535) cnt_exp++;
                if (cnt4_exp < 15) cnt4_exp++;
            end
            if (flush_i) begin
                sb_q.delete();
            end else begin
                if (xout) void'(sb_q.pop_front());
                if (xin) sb_q.push_back(in_data_i);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, rnd_data(), 1'b0, 1'b0, 1'b0);
        clock_edge();
        clock_edge();
        n_tests++;
        if (out_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b, expected 0", out_valid_o);
        end
        n_tests++;
        if (out_data_o !== {DW{1'b0}}) begin
            n_fail++; $display("FAIL reset_data: got %h, expected 0", out_data_o);
        end
        n_tests++;
        if (stall_cnt_o !== 16'd0 || stall_cnt_c4 !== 4'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d/%0d, expected 0", stall_cnt_o, stall_cnt_c4);
        end
        n_tests++;
        if (in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready_in_reset: got %b, expected 1", in_ready_o);
        end
        rst_n = 1'b1;
        drive(1'b0, {DW{1'b0}}, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b, expected 1", in_ready_o);
        end
    endtask

    task automatic test_stream();
        logic [DW-1:0] d;
        for (int i = 0; i < 4; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom, 8'(i), 8'hA5};
            drive(1'b1, d, 1'b1, 1'b0, 1'b0);
            n_tests++;
            if (in_ready_o !== 1'b1) begin
                n_fail++; $display("FAIL stream_ready[%0d]: got %b, expected 1", i, in_ready_o);
            end
            if (i == 0) begin
                n_tests++;
                if (out_valid_o !== 1'b0) begin
                    n_fail++; $display("FAIL stream_latency: got valid %b before edge, expected 0", out_valid_o);
                end
            end
            clock_edge();
            n_tests++;
            if (out_valid_o !== 1'b1 || out_data_o[7:0] !== 8'hA5) begin
                n_fail++;
                $display("FAIL stream_out[%0d]: got valid %b byte %h, expected 1 a5", i, out_valid_o, out_data_o[7:0]);
            end
        end
        drive(1'b0, {DW{1'b0}}, 1'b1, 1'b0, 1'b0);
        clock_edge();
        n_tests++;
        if (out_valid_o !== 1'b0 || out_data_o[CW-1:0] !== 8'h00) begin
            n_fail++;
            $display("FAIL stream_drain: got valid %b ctrl %h, expected 0 00", out_valid_o, out_data_o[CW-1:0]);
        end
    endtask

    task automatic test_stall();
        logic exp_rdy;
        stall_d0 = rnd_data();
        drive(1'b1, stall_d0, 1'b0, 1'b0, 1'b1);
        clock_edge();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, rnd_data(), 1'b0, 1'b0, 1'b0);
            exp_rdy = ((i + 1) < DEPTH);
            n_tests++;
            if (in_ready_o !== exp_rdy) begin
                n_fail++; $display("FAIL stall_ready[%0d]: got %b, expected %b", i, in_ready_o, exp_rdy);
            end
            clock_edge();
            n_tests++;
            if (out_valid_o !== 1'b1 || out_data_o !== stall_d0) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got %b %h, expected 1 %h", i, out_valid_o, out_data_o, stall_d0);
            end
        end
        n_tests++;
        if (stall_cnt_o !== 16'd10 || stall_cnt_c4 !== 4'd10) begin
            n_fail++; $display("FAIL stall_cnt: got %0d/%0d, expected 10", stall_cnt_o, stall_cnt_c4);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, rnd_data(), 1'b0, 1'b1, 1'b0);
        clock_edge();
        n_tests++;
        if (out_valid_o !== 1'b0 || out_data_o[CW-1:0] !== 8'h00) begin
            n_fail++; $display("FAIL flush_bubble: got valid %b ctrl %h, expected 0 00", out_valid_o, out_data_o[CW-1:0]);
        end
        n_tests++;
        if (out_data_o[DW-1:CW] !== stall_d0[DW-1:CW]) begin
            n_fail++; $display("FAIL flush_upper: got %h, expected %h", out_data_o[DW-1:CW], stall_d0[DW-1:CW]);
        end
        n_tests++;
        if (stall_cnt_o !== 16'd11) begin
            n_fail++; $display("FAIL flush_cnt: got %0d, expected 11", stall_cnt_o);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, {DW{1'b0}}, 1'b1, 1'b0, 1'b0);
            clock_edge();
            n_tests++;
            if (out_valid_o !== 1'b0) begin
                n_fail++; $display("FAIL flush_no_deliver[%0d]: got %b, expected 0", i, out_valid_o);
            end
        end
    endtask

    task automatic test_saturate();
        drive(1'b1, rnd_data(), 1'b0, 1'b0, 1'b1);
        clock_edge();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, {DW{1'b0}}, 1'b0, 1'b0, 1'b0);
            clock_edge();
        end
        n_tests++;
        if (stall_cnt_c4 !== 4'd15 || stall_cnt_o !== 16'd20) begin
            n_fail++; $display("FAIL sat_cnt: got %0d/%0d, expected 20/15", stall_cnt_o, stall_cnt_c4);
        end
        drive(1'b0, {DW{1'b0}}, 1'b0, 1'b0, 1'b1);
        clock_edge();
        n_tests++;
        if (stall_cnt_c4 !== 4'd0 || stall_cnt_o !== 16'd0) begin
            n_fail++; $display("FAIL sat_clr: got %0d/%0d, expected 0", stall_cnt_o, stall_cnt_c4);
        end
        drive(1'b0, {DW{1'b0}}, 1'b1, 1'b0, 1'b0);
        clock_edge();
        n_tests++;
        if (out_valid_o !== 1'b0 || stall_cnt_o !== 16'd0) begin
            n_fail++; $display("FAIL sat_drain: got valid %b cnt %0d, expected 0 0", out_valid_o, stall_cnt_o);
        end
    endtask

    task automatic test_random();
        logic exp_rdy;
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 9) < 7, rnd_data(), $urandom_range(0, 9) < 6,
                  $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
            exp_rdy = exp_ready();
            n_tests++;
            if (in_ready_o !== exp_rdy || in_ready_c4 !== exp_rdy) begin
                n_fail++; $display("FAIL rand_ready@%0d: got %b/%b, expected %b", i, in_ready_o, in_ready_c4, exp_rdy);
            end
            clock_edge();
            n_tests++;
            if (out_valid_o !== (sb_q.size() != 0) || out_valid_c4 !== (sb_q.size() != 0)) begin
                n_fail++; $display("FAIL rand_valid@%0d: got %b/%b, expected %0d", i, out_valid_o, out_valid_c4, sb_q.size() != 0);
            end
            if (sb_q.size() == 0) begin
                n_tests++;
                if (out_data_o[CW-1:0] !== 8'h00 || out_data_c4[CW-1:0] !== 8'h00) begin
                    n_fail++; $display("FAIL rand_bubble@%0d: got %h/%h, expected 00", i, out_data_o[CW-1:0], out_data_c4[CW-1:0]);
                end
            end
            n_tests++;
            if (stall_cnt_o !== 16'(cnt_exp) || stall_cnt_c4 !== 4'(cnt4_exp)) begin
                n_fail++; $display("FAIL rand_cnt@%0d: got %0d/%0d, expected %0d/%0d", i, stall_cnt_o, stall_cnt_c4, cnt_exp, cnt4_exp);
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, {DW{1'b0}}, 1'b1, 1'b0, 1'b0);
            clock_edge();
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d;
        drive(1'b1, rnd_data(), 1'b0, 1'b0, 1'b0);
        clock_edge();
        drive(1'b1, rnd_data(), 1'b0, 1'b0, 1'b0);
        clock_edge();
        rst_n = 1'b0;
        drive(1'b1, rnd_data(), 1'b0, 1'b0, 1'b0);
        clock_edge();
        n_tests++;
        if (out_valid_o !== 1'b0 || out_data_o !== {DW{1'b0}}) begin
            n_fail++; $display("FAIL midrst_out: got %b %h, expected 0 0", out_valid_o, out_data_o);
        end
        n_tests++;
        if (stall_cnt_o !== 16'd0 || stall_cnt_c4 !== 4'd0 || in_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL midrst_cnt_ready: got %0d/%0d rdy %b, expected 0/0 rdy 1", stall_cnt_o, stall_cnt_c4, in_ready_o);
        end
        rst_n = 1'b1;
        d = rnd_data();
        drive(1'b1, d, 1'b1, 1'b0, 1'b0);
        clock_edge();
        n_tests++;
        if (out_valid_o !== 1'b1 || out_data_o !== d) begin
            n_fail++; $display("FAIL midrst_restart: got %b %h, expected 1 %h", out_valid_o, out_data_o, d);
        end
        drive(1'b0, {DW{1'b0}}, 1'b1, 1'b0, 1'b0);
        clock_edge();
        n_tests++;
        if (out_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL midrst_drain: got %b, expected 0", out_valid_o);
        end
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        cnt_exp     = 0;
        cnt4_exp    = 0;
        stall_d0    = {DW{1'b0}};
        rst_n       = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        clr_cnt_i   = 1'b0;
        in_data_i   = {DW{1'b0}};
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_saturate();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register with a valid/ready handshake, flush and stall-cycle counting. It replaces the fixed-field, always-advancing stage registers between EX, MEM and WB, which cannot stall or flush. It carries an opaque payload whose low CTRL_W bits are control strobes (reg write, mem write, mem read, ...). Those strobes are forced to 0 whenever the stage holds a bubble, so a killed instruction never commits. It sits between any two pipeline stages and between the core pipeline and AXI-side units that backpressure.

## Interface
- DATA_W, 32+32+32+32+5+3+8 = 144: total payload width.
- CTRL_W, 8: low payload bits treated as commit strobes, zeroed in bubbles; 0 < CTRL_W <= DATA_W.
- CNT_W, 16: stall counter width.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush_i  in  1  kill all held and incoming entries this cycle.
- in_valid_i  in  1  upstream entry valid.
- in_ready_o  out  1  stage can accept an entry.
- in_data_i  in  DATA_W  upstream payload.
- out_valid_o  out  1  downstream entry valid.
- out_ready_i  in  1  downstream accepts.
- out_data_o  out  DATA_W  payload; bits [CTRL_W-1:0] = 0 whenever out_valid_o = 0.
- stall_cnt_o  out  CNT_W  cycles with out_valid_o && !out_ready_i, saturating.
- clr_cnt_i  in  1  synchronous clear of stall_cnt_o.

## Operation
- Transfer in: in_valid_i && in_ready_o && !flush_i. Transfer out: out_valid_o && out_ready_i.
- Reset: out_valid_o = 0, out_data_o = 0, stall_cnt_o = 0. in_ready_o = 1 from the first cycle after reset and also during reset. Any skid storage is empty.
- Flush:
  - Discards every held entry and any same-cycle input. Flush has priority over input.
  - Next cycle: out_valid_o = 0 and control bits = 0. Data bits above CTRL_W hold their last value.
  - Flush does not affect stall_cnt_o.
- Order is strictly FIFO. An entry is never duplicated or dropped except by flush.
- stall_cnt_o:
  - Increments by 1 per cycle with out_valid_o && !out_ready_i.
  - Saturates at 2^CNT_W-1.
  - clr_cnt_i wins over increment; the counter reads 0 the next cycle.
- Skid mode states (see Configuration):
  - EMPTY: main empty, skid empty.
  - BUSY: main full, skid empty.
  - FULL: main full, skid full.
- Skid mode transitions:
  - EMPTY->BUSY on transfer in.
  - BUSY->EMPTY on transfer out with no transfer in.
  - BUSY stays BUSY on simultaneous in and out; main takes the new data.
  - BUSY->FULL on transfer in with !out_ready_i; the new entry goes to skid.
  - FULL->BUSY on transfer out; skid moves to main.
  - Any state->EMPTY on flush.

## Timing
- Latency is 1 cycle from transfer in to out_valid_o.
- Throughput is 1 entry per cycle under continuous out_ready_i in both configurations.
- out_valid_o and out_data_o are registered.
- Skid mode: in_ready_o = (state != FULL), registered. There is no combinational path from out_ready_i to in_ready_o.
- Non-skid mode: in_ready_o = !out_valid_o || out_ready_i, combinational.
- in_ready_o does not depend on flush_i.
- Reset mid-stream behaves exactly as flush, plus clearing the counter and all data bits.
- Input-side boundaries:
  - out_ready_i low while FULL: in_ready_o stays 0 and contents are held stable.
  - in_valid_i high while in_ready_o = 0: ignored, and the upstream must hold its data.

## Configuration
- PIPE_SKID_EN defined:
  - Two-entry skid buffer with the EMPTY/BUSY/FULL FSM.
  - in_ready_o is registered, which breaks long ready chains.
- PIPE_SKID_EN undefined:
  - Single register and no FSM; in_ready_o is combinational as above.
  - Cost: one payload register.
- Handshake, flush, counter and bubble semantics are identical in both configurations.

## Structure
- The shared package pipe_pkg holds:
  - the state enum (ST_EMPTY, ST_BUSY, ST_FULL);
  - the default-width localparams;
  - per-stage CTRL field offsets for the EX/M and M/WB payload packing.
- One sub-module, sat_counter (width-parametrised saturating counter with clear), implements stall_cnt_o.
- All stage-specific payload packing lives in the instantiating stage, not in this block.

## Test plan
- Reset, then in_valid_i = 1 with data = 0xA5 in the low byte and out_ready_i = 1 for 4 cycles: out_valid_o rises 1 cycle later, 4 entries come out in order, in_ready_o stays 1.
- Full stage, out_ready_i = 0 for 10 cycles: data is held stable and stall_cnt_o = 10. In skid mode in_ready_o falls after the second accepted entry; without skid it falls after the first.
- FULL state, then flush_i pulsed together with in_valid_i: next cycle out_valid_o = 0 and out_data_o[CTRL_W-1:0] = 0; the incoming entry is not delivered.
- CNT_W = 4 with out_ready_i = 0 for 20 cycles: stall_cnt_o saturates at 15. clr_cnt_i then drives it to 0 the next cycle.
- Random in_valid_i/out_ready_i over 10k cycles with occasional flush: a scoreboard confirms FIFO order, no loss outside flush, and control bits = 0 on every cycle with out_valid_o = 0.
- Assert rst_n = 0 for 1 cycle mid-stream: all outputs return to reset values and the FSM returns to EMPTY.
